// File: rtl/game_timer_ctrl.sv
// Round sequencer for the whack-a-mole game: IDLE -> READY -> PLAY -> OVER.
// Derives seconds from tick_1k and owns the score, the countdown and the game-over blink.
module game_timer_ctrl #(
    parameter int GAME_SECONDS  = 60,
    parameter int READY_SECONDS = 3,
    parameter int TICKS_PER_SEC = 1000,
    parameter int SCORE_MAX     = 99,
    parameter int BLINK_TICKS   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1k,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [6:0] score,
    output logic [6:0] time_left,
    output logic [1:0] state,
    output logic       game_active,
    output logic       disp_blank,
    output logic       round_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int TICK_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [6:0]         GAME_T     = 7'(GAME_SECONDS);
    localparam logic [6:0]         READY_T    = 7'(READY_SECONDS);
    localparam logic [6:0]         SCORE_TOP  = 7'(SCORE_MAX);

    state_t               state_q, state_d;
    logic [6:0]           score_q, score_d;
    logic [6:0]           time_q, time_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blank_q, blank_d;
    logic                 round_done_q, round_done_d;
    logic                 sec;

    assign sec = tick_1k && (tick_cnt_q == TICK_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        score_d      = score_q;
        time_d       = time_q;
        blink_cnt_d  = blink_cnt_q;
        blank_d      = blank_q;
        round_done_d = 1'b0;
        if (tick_1k) tick_cnt_d = sec ? '0 : tick_cnt_q + 1'b1;
        else         tick_cnt_d = tick_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READY;
                    time_d  = READY_T;
                    score_d = '0;
                end
            end
            READY: begin
                if (sec) begin
                    if (time_q == 7'd1) begin
                        state_d = PLAY;
                        time_d  = GAME_T;
                    end else begin
                        time_d = time_q - 7'd1;
                    end
                end
            end
            PLAY: begin
                if (hit && !miss && score_q < SCORE_TOP)   score_d = score_q + 7'd1;
                if (miss && !hit && score_q != 7'd0)       score_d = score_q - 7'd1;
                if (sec) begin
                    if (time_q == 7'd1) begin
                        state_d      = OVER;
                        time_d       = '0;
                        round_done_d = 1'b1;
                        blink_cnt_d  = '0;
                        blank_d      = 1'b0;
                    end else begin
                        time_d = time_q - 7'd1;
                    end
                end
            end
            OVER: begin
                if (tick_1k) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blank_d     = ~blank_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                // Restart overrides a coincident blink step or second strobe.
                if (start) begin
                    state_d     = READY;
                    score_d     = '0;
                    time_d      = READY_T;
                    blank_d     = 1'b0;
                    blink_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart the second count on every transition so each counted second is whole.
        if (state_d != state_q) tick_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over all inputs.
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= '0;
            time_q       <= GAME_T;
            tick_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blank_q      <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            time_q       <= time_d;
            tick_cnt_q   <= tick_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blank_q      <= blank_d;
            round_done_q <= round_done_d;
        end
    end

    assign score       = score_q;
    assign time_left   = time_q;
    assign state       = state_q;
    assign game_active = (state_q == PLAY);
    assign disp_blank  = blank_q;
    assign round_done  = round_done_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with shortened timing: 4 ticks/s, 3 s round, 2 s ready, blink every 2 ticks, score cap 5.
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1k = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [6:0] score;
    logic [6:0] time_left;
    logic [1:0] state;
    logic       game_active;
    logic       disp_blank;
    logic       round_done;

    int checks = 0;
    int errors = 0;
    int rd_cycles = 0;
    int ga_bad = 0;

    game_timer_ctrl #(
        .GAME_SECONDS (3),
        .READY_SECONDS(2),
        .TICKS_PER_SEC(4),
        .SCORE_MAX    (5),
        .BLINK_TICKS  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1k    (tick_1k),
        .start      (start),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .time_left  (time_left),
        .state      (state),
        .game_active(game_active),
        .disp_blank (disp_blank),
        .round_done (round_done)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitors: round_done high cycles and game_active consistency with state.
    always @(negedge clk) begin
        if (round_done === 1'b1) rd_cycles++;
        if (game_active !== (state == 2'b10)) ga_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle with the given input pulses; returns 1 ns after the edge.
    task automatic step(input logic t, input logic h, input logic m, input logic s);
        @(negedge clk);
        tick_1k = t; hit = h; miss = m; start = s;
        @(posedge clk);
        #1;
        tick_1k = 1'b0; hit = 1'b0; miss = 1'b0; start = 1'b0;
    endtask

    // n tick periods of 3 clocks each, tick in the first cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_state", state, 2'b00);
        check("rst_score", score, 0);
        check("rst_time", time_left, 3);
        check("rst_active", game_active, 0);
        check("rst_blank", disp_blank, 0);
        check("rst_done", round_done, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_hit_score", score, 0);

        // Round 1: READY countdown
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("start_state", state, 2'b01);
        check("start_time", time_left, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("ready_start_state", state, 2'b01);
        check("ready_start_time", time_left, 2);
        check("ready_hit_score", score, 0);
        ticks(3);
        check("ready_3ticks_time", time_left, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ready_4th_tick_time", time_left, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check("ready_end_hold", state, 2'b01);
        ticks(1);
        check("play_state", state, 2'b10);
        check("play_time", time_left, 3);
        check("play_active", game_active, 1);

        // Scoring
        repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("score_sat_top", score, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("score_miss", score, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("score_hit_miss", score, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("play_start_state", state, 2'b10);
        check("play_start_time", time_left, 3);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("score_sat_zero", score, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        check("play_time2", time_left, 2);
        ticks(4);
        check("play_time1", time_left, 1);
        ticks(3);
        check("rd_none_yet", rd_cycles, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("over_state", state, 2'b11);
        check("over_time", time_left, 0);
        check("over_final_hit", score, 3);
        check("over_done_pulse", round_done, 1);
        check("over_active", game_active, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("over_done_clear", round_done, 0);
        check("over_hit_frozen", score, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_cycles_1", rd_cycles, 1);

        // Blink sequence: blank after ticks 1..6 = 0,1,1,0,0,1
        ticks(1); check("blink_t1", disp_blank, 0);
        ticks(1); check("blink_t2", disp_blank, 1);
        ticks(1); check("blink_t3", disp_blank, 1);
        ticks(1); check("blink_t4", disp_blank, 0);
        ticks(1); check("blink_t5", disp_blank, 0);
        ticks(1); check("blink_t6", disp_blank, 1);
        check("over_time_frozen", time_left, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_state", state, 2'b01);
        check("restart_score", score, 0);
        check("restart_time", time_left, 2);
        check("restart_blank", disp_blank, 0);

        // Round 2: reset mid-PLAY
        ticks(8);
        check("r2_play", state, 2'b10);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        check("r2_time", time_left, 2);
        check("r2_score", score, 3);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_state", state, 2'b00);
        check("midrst_score", score, 0);
        check("midrst_time", time_left, 3);
        check("midrst_done", round_done, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_rd_cycles", rd_cycles, 1);

        // Round 3: start coincident with sec in OVER
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(8);
        ticks(12);
        check("r3_over", state, 2'b11);
        check("rd_cycles_2", rd_cycles, 2);
        ticks(3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("start_sec_state", state, 2'b01);
        check("start_sec_time", time_left, 2);
        check("start_sec_blank", disp_blank, 0);
        ticks(3);
        check("r3_ready_hold", time_left, 2);
        ticks(1);
        check("r3_ready_dec", time_left, 1);

        check("game_active_only_play", ga_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
